ram_banked_clr: RTL

- Parametrised successor to the fixed 16K-word banked RAM.
- Generalised in word width, bank count and bank depth.
- Adds a hardware clear sequencer that zero-fills every word after reset or on request, with a ready flag and a dropped-write indicator.
- Sits as the Hack data-memory store; the CPU-side read/write semantics are unchanged once ready.

---
 rtl/ram_banked_clr.sv | 112 +++++++++++
 1 files changed

// File: rtl/ram_banked_clr.sv
// Banked word RAM with combinational read, synchronous write, and a hardware
// sweep that zero-fills every word after reset or on a clear request.
module ram_banked_clr #(
   parameter int WIDTH      = 16,
   parameter int BANKS      = 4,
   parameter int BANK_DEPTH = 4096,
   parameter int ADDR_W     = $clog2(BANKS * BANK_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              ready,
   output logic              load_dropped
);

   localparam int WORD_W = $clog2(BANK_DEPTH);
   localparam int BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BANKS * BANK_DEPTH - 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_clr_addr;
   logic              r_load_dropped;
   logic              w_clearing;
   logic              w_ready;
   logic              w_we;
   logic              w_drop;
   logic [ADDR_W-1:0] w_waddr;
   logic [WIDTH-1:0]  w_wdata;
   logic [WORD_W-1:0] w_wword;
   logic [WORD_W-1:0] w_rword;
   logic [BSEL_W-1:0] w_wbank;
   logic [BSEL_W-1:0] w_rbank;
   logic [WIDTH-1:0]  w_rd [BANKS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_CLEAR;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CLEAR: if (r_clr_addr == LAST) w_next = S_IDLE;
         S_IDLE:  if (clear) w_next = S_CLEAR;
         default: w_next = S_CLEAR;
      endcase
   end

   always_comb begin
      w_ready    = 1'b0;
      w_clearing = 1'b0;
      case (r_state)
         S_CLEAR: w_clearing = 1'b1;
         S_IDLE:  w_ready    = 1'b1;
         default: w_clearing = 1'b1;
      endcase
   end

   // The sweep owns the write port; clear outranks a same-cycle CPU write.
   assign w_drop  = load & (w_clearing | clear);
   assign w_we    = w_clearing | (load & ~clear);
   assign w_waddr = w_clearing ? r_clr_addr : address;
   assign w_wdata = w_clearing ? '0 : in;
   assign w_wword = w_waddr[WORD_W-1:0];
   assign w_rword = address[WORD_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clr_addr     <= '0;
         r_load_dropped <= 1'b0;
      end else begin
         r_load_dropped <= w_drop;
         if (w_clearing)
            r_clr_addr <= (r_clr_addr == LAST) ? '0 : r_clr_addr + ADDR_W'(1);
         else if (clear)
            r_clr_addr <= '0;
      end
   end

   generate
      if (BANKS > 1) begin : g_bsel
         assign w_wbank = w_waddr[WORD_W +: BSEL_W];
         assign w_rbank = address[WORD_W +: BSEL_W];
      end else begin : g_bsel_one
         assign w_wbank = '0;
         assign w_rbank = '0;
      end

      for (genvar b = 0; b < BANKS; b++) begin : g_bank
         logic [WIDTH-1:0] r_mem [BANK_DEPTH];

         always_ff @(posedge clk) begin
            if (w_we && (w_wbank == BSEL_W'(b)))
               r_mem[w_wword] <= w_wdata;
         end

         assign w_rd[b] = r_mem[w_rword];
      end
   endgenerate

   assign out          = w_ready ? w_rd[w_rbank] : '0;
   assign ready        = w_ready;
   assign load_dropped = r_load_dropped;

endmodule
